fft_spectrum_reader: RTL and testbench
======================================

FFT_SPECTRUM_READER -- requirements
Module: fft_spectrum_reader

Interface
REQ-001 SHALL have parameter POINTS, default 256: number of FFT bins read per frame.
REQ-002 SHALL have parameter MAG_SHIFT, default 2: right shift applied to magnitude before display scaling.
REQ-003 SHALL have parameter MAX_H, default 480: saturation ceiling for column height.
REQ-004 SHALL have parameter SKIP_DC, default 1: when 1, bin 0 is excluded from peak search.
REQ-005 SHALL have port sys_clk, input, 1: the single clock; all logic rises on it.
REQ-006 SHALL have port sys_rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port fft_done, input, 1: one-cycle pulse marking a new spectrum ready in the FFT output buffer.
REQ-008 SHALL have port frame_start, input, 1: display vsync level; the rising edge is the frame start.
REQ-009 SHALL have port data_req, output, 1: read request to the FFT output buffer; one bin per high cycle.
REQ-010 SHALL have port fft_point_cnt, input, 8: bin index returned by the buffer.
REQ-011 SHALL have port fft_data_out, input, 12: bin magnitude returned by the buffer.
REQ-012 SHALL have port fft_point_done, output, 1: one-cycle pulse when a full spectrum has been consumed.
REQ-013 SHALL have port col_addr, input, 8: display column read address.
REQ-014 SHALL have port col_height, output, 10: scaled height of bin col_addr.
REQ-015 SHALL have port peak_bin, output, 8: index of the largest bin of the last completed spectrum.
REQ-016 SHALL have port peak_mag, output, 12: magnitude at peak_bin.
REQ-017 SHALL have port busy, output, 1: high while a readout is in progress.

Function
REQ-018 SHALL latch fft_done into a sticky ready flag; the flag clears when a readout starts.
REQ-019 SHALL detect the frame_start rising edge with a one-register edge detector.
REQ-020 SHALL run FSM IDLE -> REQ -> DRAIN -> DONE -> IDLE.
REQ-021 IDLE -> REQ SHALL occur on the cycle after a frame_start rising edge, and only when the ready flag is set.
REQ-022 In REQ, SHALL hold data_req high for exactly POINTS consecutive cycles, counted by an internal request counter.
REQ-023 DRAIN SHALL last 1 cycle, because buffer data returns 1 cycle after each data_req cycle.
REQ-024 Each returned sample SHALL write min(fft_data_out >> MAG_SHIFT, MAX_H) to shadow height memory at address fft_point_cnt.
REQ-025 DONE SHALL last 1 cycle: pulse fft_point_done, copy the shadow peak to peak_bin/peak_mag, and swap the shadow and display banks.
REQ-026 Peak search SHALL use strict greater-than, so the lowest index wins on ties; bin 0 is ignored when SKIP_DC=1.
REQ-027 Height memory SHALL be double-banked POINTS x 10 bits; col_height SHALL be registered with a 1-cycle latency from col_addr and SHALL read only the display bank.
REQ-028 A frame_start edge while busy SHALL be ignored; an fft_done pulse while busy SHALL set the ready flag for the next frame.
REQ-029 A frame_start edge without the ready flag set SHALL leave the FSM in IDLE, and the display bank is unchanged.
REQ-030 fft_point_cnt out of range (>= POINTS) SHALL not write to the height memory.
REQ-031 busy SHALL be high in REQ, DRAIN and DONE.

Reset
REQ-032 On sys_rst_n=0, including mid-readout, SHALL return to IDLE on the next edge with data_req=0, fft_point_done=0, busy=0, peak_bin=0, peak_mag=0, ready flag=0, bank select=0, and col_height=0.
REQ-033 Height memory contents SHALL NOT require reset.

Structure
REQ-034 FSM state encoding and the POINTS/MAX_H defaults SHALL live in shared package fft_disp_pkg.
REQ-035 The double-banked height memory SHALL be sub-module spec_col_ram (1 write port, 1 registered read port).

Verification
REQ-036 fft_done, then frame_start edge, with magnitudes equal to 4*bin -> data_req high exactly 256 cycles; fft_point_done 258 cycles after the start cycle; col_height[k] = min(k, 480).
REQ-037 Bin 37 = 4095, all other bins 100 -> peak_bin=37, peak_mag=4095, col_height[37]=480 (saturated).
REQ-038 Bin 0 = 4000, bin 5 = 200, bin 9 = 200, others 0 -> peak_bin=5 (DC skipped, tie resolved to lowest index).
REQ-039 frame_start edge with no prior fft_done -> data_req stays 0; second frame_start edge during REQ -> ignored, exactly 256 requests issued.
REQ-040 sys_rst_n low at request 100 -> next cycle data_req=0, busy=0; no fft_point_done; display bank unchanged.

Source files
------------

// File: rtl/fft_disp_pkg.sv
// Shared definitions for the FFT spectrum display path.
// Holds the readout FSM encoding, the default frame/height limits and the
// magnitude-to-column-height scaling helper.
package fft_disp_pkg;

  localparam int POINTS_DEF = 256;
  localparam int MAX_H_DEF  = 480;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  // Shift the raw magnitude down, then clamp to the display ceiling.
  function automatic logic [9:0] scale_height(input logic [11:0] mag,
                                              input int shift,
                                              input int max_h);
    logic [11:0] shifted;
    shifted = mag >> shift;
    if (int'(shifted) > max_h) return 10'(max_h);
    return shifted[9:0];
  endfunction

endpackage

// File: rtl/spec_col_ram.sv
// Double-banked column height memory.
// Ports:
//   clk         - clock
//   rst_n       - synchronous active-low reset (read register only)
//   we/waddr    - write enable and {bank, index} write address
//   wdata       - 10-bit height to store
//   raddr       - {bank, index} read address
//   rdata       - registered read data, one cycle after raddr
module spec_col_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [9:0]    wdata,
  input  logic [AW:0]   raddr,
  output logic [9:0]    rdata
);

  logic [9:0] mem [2**(AW+1)];

  // Storage contents are never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_spectrum_reader.sv
// Reads a completed FFT spectrum into a shadow height bank once per display
// frame, tracks the peak bin, and swaps banks so the display always sees a
// complete spectrum.
// Ports:
//   sys_clk, sys_rst_n      - clock, synchronous active-low reset
//   fft_done                - new spectrum ready pulse (sticky-latched)
//   frame_start             - vsync level, rising edge starts a readout
//   data_req                - one bin request per high cycle
//   fft_point_cnt/data_out  - returned bin index and magnitude (1 cycle later)
//   fft_point_done          - pulse when the full spectrum has been consumed
//   col_addr/col_height     - display read port, 1-cycle latency
//   peak_bin/peak_mag       - peak of the last completed spectrum
//   busy                    - readout in progress
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | waiting for frame edge with a spectrum ready
// ST_REQ   | issuing POINTS consecutive bin requests
// ST_DRAIN | absorbing the last returned sample
// ST_DONE  | publish peak, swap banks, pulse fft_point_done
module fft_spectrum_reader
  import fft_disp_pkg::*;
#(
  parameter int POINTS    = POINTS_DEF,
  parameter int MAG_SHIFT = 2,
  parameter int MAX_H     = MAX_H_DEF,
  parameter int SKIP_DC   = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        fft_done,
  input  logic        frame_start,
  output logic        data_req,
  input  logic [7:0]  fft_point_cnt,
  input  logic [11:0] fft_data_out,
  output logic        fft_point_done,
  input  logic [7:0]  col_addr,
  output logic [9:0]  col_height,
  output logic [7:0]  peak_bin,
  output logic [11:0] peak_mag,
  output logic        busy
);

  localparam int AW = (POINTS > 1) ? $clog2(POINTS) : 1;

  rd_state_t   state, state_nxt;
  logic        fs_q;
  logic        ready;
  logic        bank_sel;
  logic        req_q;
  logic [8:0]  req_cnt;
  logic [7:0]  pk_bin_s;
  logic [11:0] pk_mag_s;

  logic fs_rise, start, sample_ok, dc_bin, peak_hit;

  assign fs_rise   = frame_start & ~fs_q;
  assign start     = (state == ST_IDLE) && fs_rise && ready;
  assign sample_ok = req_q && (int'(fft_point_cnt) < POINTS);
  assign dc_bin    = (SKIP_DC != 0) && (fft_point_cnt == 8'd0);
  assign peak_hit  = sample_ok && !dc_bin && (fft_data_out > pk_mag_s);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    data_req       = 1'b0;
    fft_point_done = 1'b0;
    busy           = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        data_req = 1'b1;
        if (req_cnt == 9'd0) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE: begin
        fft_point_done = 1'b1;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      fs_q     <= 1'b0;
      ready    <= 1'b0;
      bank_sel <= 1'b0;
      req_q    <= 1'b0;
      req_cnt  <= '0;
      pk_bin_s <= '0;
      pk_mag_s <= '0;
      peak_bin <= '0;
      peak_mag <= '0;
    end else begin
      fs_q  <= frame_start;
      req_q <= data_req;
      // A new spectrum arriving mid-readout must survive the start clear.
      if (fft_done)   ready <= 1'b1;
      else if (start) ready <= 1'b0;

      if (start)                               req_cnt <= 9'(POINTS - 1);
      else if (data_req && req_cnt != 9'd0)    req_cnt <= req_cnt - 9'd1;

      if (start) begin
        pk_bin_s <= '0;
        pk_mag_s <= '0;
      end else if (peak_hit) begin
        pk_bin_s <= fft_point_cnt;
        pk_mag_s <= fft_data_out;
      end

      if (state == ST_DONE) begin
        peak_bin <= pk_bin_s;
        peak_mag <= pk_mag_s;
        bank_sel <= ~bank_sel;
      end
    end
  end

  spec_col_ram #(.AW(AW)) u_col_ram (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .we    (sample_ok),
    .waddr ({~bank_sel, fft_point_cnt[AW-1:0]}),
    .wdata (scale_height(fft_data_out, MAG_SHIFT, MAX_H)),
    .raddr ({bank_sel, col_addr[AW-1:0]}),
    .rdata (col_height)
  );

endmodule

// File: tb/tb_fft_spectrum_reader.sv
// Self-checking bench for fft_spectrum_reader with a behavioural FFT buffer
// that answers each data_req one cycle later.
module tb_fft_spectrum_reader;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        fft_done = 1'b0;
  logic        frame_start = 1'b0;
  logic        data_req;
  logic [7:0]  fft_point_cnt = '0;
  logic [11:0] fft_data_out = '0;
  logic        fft_point_done;
  logic [7:0]  col_addr = '0;
  logic [9:0]  col_height;
  logic [7:0]  peak_bin;
  logic [11:0] peak_mag;
  logic        busy;

  always #5 sys_clk = ~sys_clk;

  fft_spectrum_reader dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .fft_done       (fft_done),
    .frame_start    (frame_start),
    .data_req       (data_req),
    .fft_point_cnt  (fft_point_cnt),
    .fft_data_out   (fft_data_out),
    .fft_point_done (fft_point_done),
    .col_addr       (col_addr),
    .col_height     (col_height),
    .peak_bin       (peak_bin),
    .peak_mag       (peak_mag),
    .busy           (busy)
  );

  logic [11:0] mag [256];
  logic [9:0]  disp_exp [256];
  logic [9:0]  shadow_exp [256];
  logic [31:0] ht_q [$];
  logic [31:0] pk_q [$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // FFT output buffer: data for a request appears in the following cycle.
  initial begin : buf_model
    int addr;
    logic req_prev;
    addr = 0;
    req_prev = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (req_prev) begin
        fft_point_cnt = 8'(addr);
        fft_data_out  = mag[addr];
        addr = (addr + 1) % 256;
      end else begin
        addr = 0;
      end
      req_prev = data_req;
    end
  end

  task automatic pulse_done();
    @(negedge sys_clk); fft_done = 1'b1;
    @(negedge sys_clk); fft_done = 1'b0;
  endtask

  task automatic read_back(input string tag);
    for (int k = 0; k <= 256; k++) begin
      @(negedge sys_clk);
      if (k > 0) chk(tag, 32'(col_height), ht_q.pop_front());
      if (k < 256) begin
        col_addr = 8'(k);
        ht_q.push_back(32'(disp_exp[k]));
      end
    end
  endtask

  // Expected heights and peak (DC skipped, strict greater-than).
  task automatic predict();
    logic [11:0] best_mag;
    logic [7:0]  best_bin;
    logic [11:0] s;
    best_mag = '0;
    best_bin = '0;
    for (int k = 0; k < 256; k++) begin
      s = mag[k] >> 2;
      shadow_exp[k] = (s > 12'd480) ? 10'd480 : s[9:0];
      if (k != 0 && mag[k] > best_mag) begin
        best_mag = mag[k];
        best_bin = 8'(k);
      end
    end
    pk_q.push_back({12'd0, best_bin, best_mag});
  endtask

  task automatic run_frame(input bit refire, input bit mid_done);
    int nreq;
    int done_at;
    logic [31:0] pk;
    nreq = 0;
    done_at = 0;
    predict();
    @(negedge sys_clk); frame_start = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge sys_clk);
      if (data_req) nreq++;
      if (k == 3) frame_start = 1'b0;
      if (refire && k == 50) frame_start = 1'b1;
      if (refire && k == 53) frame_start = 1'b0;
      fft_done = (mid_done && k == 80);
      if (k == 100) chk("busy_in_req", 32'(busy), 32'd1);
      if (fft_point_done) begin
        done_at = k;
        break;
      end
    end
    fft_done = 1'b0;
    chk("req_count", nreq, 256);
    chk("done_latency", done_at, 258);
    @(negedge sys_clk);
    pk = pk_q.pop_front();
    chk("peak_bin", 32'(peak_bin), 32'(pk[19:12]));
    chk("peak_mag", 32'(peak_mag), 32'(pk[11:0]));
    chk("busy_after", 32'(busy), 32'd0);
    for (int k = 0; k < 256; k++) disp_exp[k] = shadow_exp[k];
  endtask

  initial begin
    int nreq;
    int seen_done;
    repeat (3) @(negedge sys_clk);
    chk("rst_data_req", 32'(data_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(fft_point_done), 0);
    chk("rst_peak_bin", 32'(peak_bin), 0);
    chk("rst_peak_mag", 32'(peak_mag), 0);
    chk("rst_col_height", 32'(col_height), 0);
    sys_rst_n = 1'b1;

    // Ramp: magnitude 4*k gives height k.
    for (int k = 0; k < 256; k++) mag[k] = 12'(4 * k);
    pulse_done();
    run_frame(1'b0, 1'b0);
    read_back("ramp_h");

    // Single saturating peak; a new spectrum arrives during this readout.
    for (int k = 0; k < 256; k++) mag[k] = 12'd100;
    mag[37] = 12'd4095;
    pulse_done();
    run_frame(1'b0, 1'b1);
    read_back("peak37_h");

    // DC skip and tie-break; started only by the fft_done latched mid-readout.
    for (int k = 0; k < 256; k++) mag[k] = 12'd0;
    mag[0] = 12'd4000;
    mag[5] = 12'd200;
    mag[9] = 12'd200;
    run_frame(1'b0, 1'b0);
    read_back("dc_h");

    // Frame edge without a ready spectrum does nothing.
    nreq = 0;
    @(negedge sys_clk); frame_start = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge sys_clk);
      if (k == 3) frame_start = 1'b0;
      if (data_req || busy) nreq++;
    end
    chk("no_ready_reqs", nreq, 0);
    read_back("no_ready_h");

    // Retrigger during readout is ignored.
    for (int k = 0; k < 256; k++) mag[k] = 12'(4 * k);
    pulse_done();
    run_frame(1'b1, 1'b0);
    read_back("refire_h");

    // Reset at the 100th request.
    for (int k = 0; k < 256; k++) mag[k] = 12'd4000;
    pulse_done();
    nreq = 0;
    @(negedge sys_clk); frame_start = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge sys_clk);
      if (k == 3) frame_start = 1'b0;
      if (data_req) nreq++;
      if (nreq == 100) break;
    end
    chk("rst_reached_100", nreq, 100);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk("midrst_data_req", 32'(data_req), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(fft_point_done), 0);
    chk("midrst_peak_bin", 32'(peak_bin), 0);
    chk("midrst_peak_mag", 32'(peak_mag), 0);
    chk("midrst_col_height", 32'(col_height), 0);
    frame_start = 1'b0;
    sys_rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge sys_clk);
      if (fft_point_done || data_req) seen_done++;
    end
    chk("midrst_no_activity", seen_done, 0);
    read_back("midrst_h");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
